// File: rtl/regfile_wb_queue_pkg.sv
// Shared widths for the register-file write-back queue.
// A queue entry is {rd, data}; the rd field sits in the upper REG_W bits.
package regfile_wb_queue_pkg;

   localparam int N_DEF     = 32;
   localparam int DEPTH_DEF = 4;
   localparam int REG_W     = 5;

   function automatic int entry_w(input int n);
      return n + REG_W;
   endfunction

endpackage

// File: rtl/regfile_wb_queue_if.sv
// Producer, write-port and bypass signals of the write-back queue.
// The slave side is the queue; the master side drives results and operand addresses.
interface regfile_wb_queue_if
   import regfile_wb_queue_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int DEPTH = DEPTH_DEF
);

   logic                   ld_valid;
   logic [REG_W-1:0]       ld_rd;
   logic [N-1:0]           ld_data;
   logic                   ld_ready;
   logic                   alu_valid;
   logic [REG_W-1:0]       alu_rd;
   logic [N-1:0]           alu_data;
   logic                   alu_ready;
   logic                   wr_en;
   logic [REG_W-1:0]       wr_reg;
   logic [N-1:0]           wr_data;
   logic [REG_W-1:0]       rs1;
   logic [REG_W-1:0]       rs2;
   logic                   byp1_hit;
   logic                   byp2_hit;
   logic [N-1:0]           byp1_data;
   logic [N-1:0]           byp2_data;
   logic [$clog2(DEPTH):0] count;

   modport slave (
      input  ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, rs1, rs2,
      output ld_ready, alu_ready, wr_en, wr_reg, wr_data,
             byp1_hit, byp2_hit, byp1_data, byp2_data, count
   );

   modport master (
      output ld_valid, ld_rd, ld_data, alu_valid, alu_rd, alu_data, rs1, rs2,
      input  ld_ready, alu_ready, wr_en, wr_reg, wr_data,
             byp1_hit, byp2_hit, byp1_data, byp2_data, count
   );

endinterface

// File: rtl/regfile_wb_queue_wb_fifo.sv
// Circular buffer: up to two enqueues (entry0 older than entry1) and one dequeue per cycle.
// Storage and head pointer are exposed so the parent can search pending entries.
module wb_fifo
   import regfile_wb_queue_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   enq0,
   input  logic [entry_w(N)-1:0]                  entry0,
   input  logic                                   enq1,
   input  logic [entry_w(N)-1:0]                  entry1,
   input  logic                                   deq,
   output logic [DEPTH-1:0][entry_w(N)-1:0]       entries,
   output logic [$clog2(DEPTH)-1:0]               head_ptr,
   output logic [$clog2(DEPTH):0]                 count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] tail_ptr;

   // Validity is implied by head_ptr/count, so clearing count empties the queue at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         entries  <= '0;
      end else begin
         if (enq0) entries[tail_ptr] <= entry0;
         if (enq1) entries[tail_ptr + PW'(1)] <= entry1;
         tail_ptr <= tail_ptr + PW'(enq0) + PW'(enq1);
         if (deq) head_ptr <= head_ptr + PW'(1);
         count <= count + CW'(enq0) + CW'(enq1) - CW'(deq);
      end
   end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue in front of the register file write port: serializes load and ALU
// results in program order, drops x0 writes, and forwards pending values to operand reads.
module regfile_wb_queue
   import regfile_wb_queue_pkg::*;
#(
   parameter int N     = N_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   regfile_wb_queue_if.slave  bus
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = entry_w(N);

   logic [DEPTH-1:0][EW-1:0] entries;
   logic [PW-1:0]            head_ptr;
   logic [CW-1:0]            count;
   logic [CW-1:0]            free;
   logic                     nonempty;
   logic                     ld_enq;
   logic                     alu_enq;
   logic [EW-1:0]            head_entry;

   assign nonempty = (count != '0);
   // The head always pops this edge, so a full queue still has one slot to give.
   assign free          = CW'(DEPTH) - count + CW'(nonempty);
   assign bus.ld_ready  = (free >= CW'(1));
   assign bus.alu_ready = (free >= CW'(1) + CW'(bus.ld_valid && bus.ld_ready));

   assign ld_enq  = bus.ld_valid  && bus.ld_ready  && (bus.ld_rd  != '0);
   assign alu_enq = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);

   wb_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .enq0     (ld_enq || alu_enq),
      .entry0   (ld_enq ? {bus.ld_rd, bus.ld_data} : {bus.alu_rd, bus.alu_data}),
      .enq1     (ld_enq && alu_enq),
      .entry1   ({bus.alu_rd, bus.alu_data}),
      .deq      (nonempty),
      .entries  (entries),
      .head_ptr (head_ptr),
      .count    (count)
   );

   assign head_entry  = entries[head_ptr];
   assign bus.wr_en   = nonempty;
   assign bus.wr_reg  = nonempty ? head_entry[EW-1 -: REG_W] : '0;
   assign bus.wr_data = nonempty ? head_entry[N-1:0] : '0;
   assign bus.count   = count;

   // Walk from head toward tail so the last match is the youngest pending value.
   function automatic logic [N:0] youngest(
      input logic [REG_W-1:0]         rs,
      input logic [DEPTH-1:0][EW-1:0] ent,
      input logic [PW-1:0]            hd,
      input logic [CW-1:0]            cnt
   );
      logic [N:0]    res;
      logic [PW-1:0] idx;
      res = '0;
      idx = hd;
      if (rs != '0) begin
         for (int k = 0; k < DEPTH; k++) begin
            idx = hd + PW'(k);
            if ((CW'(k) < cnt) && (ent[idx][EW-1 -: REG_W] == rs))
               res = {1'b1, ent[idx][N-1:0]};
         end
      end
      return res;
   endfunction

   assign {bus.byp1_hit, bus.byp1_data} = youngest(bus.rs1, entries, head_ptr, count);
   assign {bus.byp2_hit, bus.byp2_data} = youngest(bus.rs2, entries, head_ptr, count);

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: directed scenarios plus random traffic checked
// against a queue-of-writes reference model and a shadow register file.
module tb_regfile_wb_queue;

   localparam int N     = 32;
   localparam int DEPTH = 4;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   int          errors = 0;
   int          checks = 0;
   ent_t        q[$];
   logic [31:0] rf_dut[32];
   logic [31:0] rf_model[32];

   regfile_wb_queue_if #(.N(N), .DEPTH(DEPTH)) bus();

   regfile_wb_queue #(.N(N), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic void model_byp(input logic [4:0] rs, output logic hit, output logic [31:0] d);
      hit = 1'b0;
      d   = '0;
      if (rs != 0) begin
         foreach (q[i]) begin
            if (q[i].rd == rs) begin
               hit = 1'b1;
               d   = q[i].data;
            end
         end
      end
   endfunction

   task automatic drive(input logic ldv, input logic [4:0] ldrd, input logic [31:0] lddata,
                        input logic aluv, input logic [4:0] alurd, input logic [31:0] aludata,
                        input logic [4:0] r1, input logic [4:0] r2);
      bus.ld_valid  = ldv;
      bus.ld_rd     = ldrd;
      bus.ld_data   = lddata;
      bus.alu_valid = aluv;
      bus.alu_rd    = alurd;
      bus.alu_data  = aludata;
      bus.rs1       = r1;
      bus.rs2       = r2;
   endtask

   // One cycle: drive after negedge, check before posedge, then advance the model.
   task automatic step(input logic ldv, input logic [4:0] ldrd, input logic [31:0] lddata,
                       input logic aluv, input logic [4:0] alurd, input logic [31:0] aludata,
                       input logic [4:0] r1, input logic [4:0] r2);
      int          sz;
      int          free;
      logic        exp_ld_rdy;
      logic        exp_alu_rdy;
      logic        h;
      logic [31:0] d;
      @(negedge clk);
      drive(ldv, ldrd, lddata, aluv, alurd, aludata, r1, r2);
      #2;
      sz          = q.size();
      free        = DEPTH - sz + ((sz > 0) ? 1 : 0);
      exp_ld_rdy  = (free >= 1);
      exp_alu_rdy = (free >= 1 + ((ldv && exp_ld_rdy) ? 1 : 0));
      check_val("count", bus.count, sz);
      check_val("wr_en", bus.wr_en, sz > 0);
      check_val("wr_reg", bus.wr_reg, (sz > 0) ? q[0].rd : 5'd0);
      check_val("wr_data", bus.wr_data, (sz > 0) ? q[0].data : 32'd0);
      check_val("ld_ready", bus.ld_ready, exp_ld_rdy);
      check_val("alu_ready", bus.alu_ready, exp_alu_rdy);
      model_byp(r1, h, d);
      check_val("byp1_hit", bus.byp1_hit, h);
      check_val("byp1_data", bus.byp1_data, d);
      model_byp(r2, h, d);
      check_val("byp2_hit", bus.byp2_hit, h);
      check_val("byp2_data", bus.byp2_data, d);
      if (bus.wr_en) rf_dut[bus.wr_reg] = bus.wr_data;
      @(posedge clk);
      if (sz > 0) begin
         rf_model[q[0].rd] = q[0].data;
         void'(q.pop_front());
      end
      if (ldv && exp_ld_rdy && ldrd != 0) q.push_back('{rd: ldrd, data: lddata});
      if (aluv && exp_alu_rdy && alurd != 0) q.push_back('{rd: alurd, data: aludata});
   endtask

   task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) begin
         rf_dut[i]   = '0;
         rf_model[i] = '0;
      end

      // Reset held with producers active
      drive(1'b1, 5'd3, 32'h33, 1'b1, 5'd4, 32'h44, 5'd3, 5'd4);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst_wr_en", bus.wr_en, 1'b0);
      check_val("rst_count", bus.count, 0);
      check_val("rst_ld_ready", bus.ld_ready, 1'b1);
      check_val("rst_alu_ready", bus.alu_ready, 1'b1);
      check_val("rst_byp1_hit", bus.byp1_hit, 1'b0);
      check_val("rst_byp2_hit", bus.byp2_hit, 1'b0);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
      rst = 1'b1;

      // Single ALU result
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
      idle(5'd5, 5'd0);
      idle(5'd5, 5'd0);

      // Same-cycle load and ALU: load is older
      step(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 5'd3, 5'd4);
      repeat (3) idle(5'd3, 5'd4);

      // x0 destination is consumed but never written
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hFF, 5'd0, 5'd0);
      repeat (2) idle(5'd0, 5'd0);

      // Both producers every cycle until the queue backs up
      for (int i = 0; i < 4; i++)
         step(1'b1, 5'(2*i+1), 32'h100 + i, 1'b1, 5'(2*i+2), 32'h200 + i, 5'(2*i+1), 5'(2*i+2));
      repeat (6) idle(5'd1, 5'd8);

      // Two pending writes to the same register
      step(1'b1, 5'd7, 32'h1, 1'b1, 5'd7, 32'h2, 5'd0, 5'd7);
      repeat (4) idle(5'd0, 5'd7);
      check_val("rf7_final", rf_dut[7], 32'h2);

      // Reset in the middle of operation
      step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd1, 5'd2);
      step(1'b1, 5'd3, 32'hA3, 1'b1, 5'd4, 32'hA4, 5'd1, 5'd2);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd4);
      #1;
      check_val("mid_count_pre", bus.count, 3);
      rst = 1'b0;
      #1;
      check_val("mid_rst_wr_en", bus.wr_en, 1'b0);
      check_val("mid_rst_count", bus.count, 0);
      check_val("mid_rst_byp1", bus.byp1_hit, 1'b0);
      q.delete();
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) idle(5'd3, 5'd4);

      // Random traffic over a small register range to force collisions and x0 hits
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
              $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      repeat (6) idle(5'd0, 5'd0);
      for (int i = 0; i < 32; i++)
         check_val($sformatf("rf[%0d]", i), rf_dut[i], rf_model[i]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
